// File: rtl/cnn_job_launcher.sv
// cnn_job_launcher: initiator side of the CNN engine start/busy/done handshake.
// Accepts a layer-count job command and launches the engine once per layer,
// waiting for busy acknowledgement and the done pulse between launches.
// Optional per-phase watchdog: define CNN_LAUNCH_TIMEOUT_EN.
module cnn_job_launcher #(
    parameter int LAYER_W        = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [LAYER_W-1:0] cmd_layers,
    input  logic               abort,
    output logic               eng_start,
    input  logic               eng_busy,
    input  logic               eng_done,
    output logic [LAYER_W-1:0] layer_idx,
    output logic               seq_busy,
    output logic               seq_done,
    output logic [1:0]         seq_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_ACK   = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [LAYER_W-1:0] LAYER_ONE = LAYER_W'(1);
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ABORT   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Reject watchdog limits that cannot form a meaningful wait window.
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("cnn_job_launcher: TIMEOUT_CYCLES must be at least 2");
    end

    state_t             state_q, state_d;
    logic [LAYER_W-1:0] layer_idx_q, layer_idx_d;
    logic [LAYER_W-1:0] layers_q, layers_d;
    logic [1:0]         seq_err_q, seq_err_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               eng_start_q, eng_start_d;
    logic               seq_busy_q, seq_busy_d;
    logic               seq_done_q, seq_done_d;
    logic               last_layer_s;
    logic               timeout_s;

`ifdef CNN_LAUNCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

    // Wait counter restarts on every entry into a wait state and counts while staying there.
    always_comb begin
        wait_cnt_d = '0;
        if (((state_q == S_ACK) || (state_q == S_RUN)) && (state_d == state_q)) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end else begin
            wait_cnt_d = '0;
        end
    end

    // Wait counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign timeout_s = (wait_cnt_q == CNT_LIMIT);
`else
    assign timeout_s = 1'b0;
`endif

    assign last_layer_s = (layer_idx_q == (layers_q - LAYER_ONE));

    // Next-state logic: abort beats engine events, which beat the watchdog.
    always_comb begin
        state_d     = state_q;
        layer_idx_d = layer_idx_q;
        layers_d    = layers_q;
        seq_err_d   = seq_err_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    layers_d    = cmd_layers;
                    layer_idx_d = '0;
                    seq_err_d   = ERR_NONE;
                    if (cmd_layers == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_START;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (abort) begin
                    seq_err_d = ERR_ABORT;
                    state_d   = S_DONE;
                end else begin
                    state_d = S_ACK;
                end
            end
            S_ACK, S_RUN: begin
                if (abort) begin
                    seq_err_d = ERR_ABORT;
                    state_d   = S_DONE;
                end else if (eng_done) begin
                    // A done seen in S_ACK is a fast engine that skipped visible busy.
                    if (last_layer_s) begin
                        state_d = S_DONE;
                    end else begin
                        layer_idx_d = layer_idx_q + LAYER_ONE;
                        state_d     = S_START;
                    end
                end else if (eng_busy && (state_q == S_ACK)) begin
                    state_d = S_RUN;
                end else if (timeout_s) begin
                    seq_err_d = ERR_TIMEOUT;
                    state_d   = S_DONE;
                end else begin
                    state_d = state_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decodes are taken from the next state so every port comes straight off a flop.
    always_comb begin
        cmd_ready_d = (state_d == S_IDLE);
        eng_start_d = (state_d == S_START);
        seq_busy_d  = (state_d == S_START) || (state_d == S_ACK) || (state_d == S_RUN);
        seq_done_d  = (state_d == S_DONE);
    end

    // State, job context and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            layer_idx_q <= '0;
            layers_q    <= '0;
            seq_err_q   <= ERR_NONE;
            cmd_ready_q <= 1'b0;
            eng_start_q <= 1'b0;
            seq_busy_q  <= 1'b0;
            seq_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            layer_idx_q <= layer_idx_d;
            layers_q    <= layers_d;
            seq_err_q   <= seq_err_d;
            cmd_ready_q <= cmd_ready_d;
            eng_start_q <= eng_start_d;
            seq_busy_q  <= seq_busy_d;
            seq_done_q  <= seq_done_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign eng_start = eng_start_q;
    assign seq_busy  = seq_busy_q;
    assign seq_done  = seq_done_q;
    assign layer_idx = layer_idx_q;
    assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_cnn_job_launcher.sv
// Directed self-checking bench for cnn_job_launcher with a 103-cycle-per-layer engine model.
module tb_cnn_job_launcher;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [LW-1:0] cmd_layers = '0;
    logic          abort = 1'b0;
    logic          eng_start;
    logic          eng_busy;
    logic          eng_done;
    logic [LW-1:0] layer_idx;
    logic          seq_busy;
    logic          seq_done;
    logic [1:0]    seq_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    cnn_job_launcher #(.LAYER_W(LW), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_layers(cmd_layers), .abort(abort), .eng_start(eng_start),
        .eng_busy(eng_busy), .eng_done(eng_done), .layer_idx(layer_idx),
        .seq_busy(seq_busy), .seq_done(seq_done), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: busy from the cycle after start, done pulse 102 cycles after start.
    bit model_en = 1'b1;
    int eng_cnt  = 0;
    always @(posedge clk) begin
        if (reset) eng_cnt <= 0;
        else if (eng_start && model_en) eng_cnt <= 1;
        else if (eng_cnt != 0 && eng_cnt < 102) eng_cnt <= eng_cnt + 1;
        else eng_cnt <= 0;
    end
    assign eng_busy = model_en && (eng_cnt >= 1) && (eng_cnt <= 101);
    assign eng_done = model_en && (eng_cnt == 102);

    // Pulse recorder, sampled mid-cycle.
    int            n_start = 0;
    int            n_done  = 0;
    int            st_cyc[32];
    logic [LW-1:0] st_idx[32];
    always @(negedge clk) begin
        if (eng_start) begin
            if (n_start < 32) begin
                st_cyc[n_start] = cyc;
                st_idx[n_start] = layer_idx;
            end
            n_start++;
        end
        if (seq_done) n_done++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int limit, input string tag);
        int k;
        k = 0;
        while (seq_done !== 1'b1 && k < limit) begin
            tick();
            k++;
        end
        chk(tag, seq_done, 1'b1);
    endtask

    initial begin
        int c, s0, d0, k;

        // Reset state
        repeat (3) tick();
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_eng_start", eng_start, 1'b0);
        chk("rst_seq_busy", seq_busy, 1'b0);
        chk("rst_seq_done", seq_done, 1'b0);
        chk("rst_layer_idx", layer_idx, 8'd0);
        chk("rst_seq_err", seq_err, 2'b00);
        reset = 1'b0;
        tick();
        chk("post_rst_ready", cmd_ready, 1'b1);

        // One-layer job
        s0 = n_start;
        cmd_valid = 1'b1; cmd_layers = 8'd1; c = cyc;
        tick();
        cmd_valid = 1'b0;
        chk("j1_start", eng_start, 1'b1);
        chk("j1_idx", layer_idx, 8'd0);
        chk("j1_busy", seq_busy, 1'b1);
        chk("j1_not_ready", cmd_ready, 1'b0);
        wait_done(200, "j1_done_seen");
        chk("j1_done_cyc", cyc, c + 104);
        chk("j1_err", seq_err, 2'b00);
        tick();
        chk("j1_nstart", n_start - s0, 1);
        chk("j1_idle_ready", cmd_ready, 1'b1);

        // Three-layer job
        s0 = n_start; d0 = n_done;
        cmd_valid = 1'b1; cmd_layers = 8'd3; c = cyc;
        tick();
        cmd_valid = 1'b0;
        wait_done(400, "j3_done_seen");
        chk("j3_done_cyc", cyc, c + 310);
        tick();
        chk("j3_nstart", n_start - s0, 3);
        chk("j3_ndone", n_done - d0, 1);
        chk("j3_st0_cyc", st_cyc[s0], c + 1);
        chk("j3_st1_cyc", st_cyc[s0+1], c + 104);
        chk("j3_st2_cyc", st_cyc[s0+2], c + 207);
        chk("j3_st0_idx", st_idx[s0], 8'd0);
        chk("j3_st1_idx", st_idx[s0+1], 8'd1);
        chk("j3_st2_idx", st_idx[s0+2], 8'd2);
        chk("j3_idx_hold", layer_idx, 8'd2);

        // Zero-layer job with cmd_valid held high
        s0 = n_start;
        cmd_valid = 1'b1; cmd_layers = 8'd0;
        tick();
        chk("z_done_c1", seq_done, 1'b1);
        chk("z_nostart_c1", eng_start, 1'b0);
        chk("z_ready_c1", cmd_ready, 1'b0);
        tick();
        chk("z_ready_c2", cmd_ready, 1'b1);
        chk("z_nodone_c2", seq_done, 1'b0);
        tick();
        chk("z_reaccept_done_c3", seq_done, 1'b1);
        cmd_valid = 1'b0;
        repeat (2) tick();
        chk("z_nstart", n_start - s0, 0);

        // Abort coinciding with eng_done on layer 0 of a 2-layer job
        s0 = n_start;
        cmd_valid = 1'b1; cmd_layers = 8'd2;
        tick();
        cmd_valid = 1'b0;
        k = 0;
        while (eng_done !== 1'b1 && k < 300) begin
            tick();
            k++;
        end
        chk("ab_eng_done_seen", eng_done, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_done", seq_done, 1'b1);
        chk("ab_err", seq_err, 2'b01);
        chk("ab_busy", seq_busy, 1'b0);
        chk("ab_idx", layer_idx, 8'd0);
        repeat (5) tick();
        chk("ab_nstart", n_start - s0, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_idle_ignored_ready", cmd_ready, 1'b1);
        chk("ab_idle_ignored_done", seq_done, 1'b0);
        chk("ab_err_sticky", seq_err, 2'b01);

        // Reset during S_RUN of layer 1
        s0 = n_start;
        cmd_valid = 1'b1; cmd_layers = 8'd2;
        tick();
        cmd_valid = 1'b0;
        chk("rr_err_cleared", seq_err, 2'b00);
        k = 0;
        while ((n_start - s0) < 2 && k < 400) begin
            tick();
            k++;
        end
        chk("rr_second_start", n_start - s0, 2);
        repeat (10) tick();
        chk("rr_busy_run", seq_busy, 1'b1);
        chk("rr_idx_run", layer_idx, 8'd1);
        d0 = n_done;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rr_busy", seq_busy, 1'b0);
        chk("rr_idx", layer_idx, 8'd0);
        chk("rr_ready_in_rst", cmd_ready, 1'b0);
        chk("rr_nodone", seq_done, 1'b0);
        tick();
        chk("rr_ready_after", cmd_ready, 1'b1);
        chk("rr_ndone", n_done - d0, 0);

`ifdef CNN_LAUNCH_TIMEOUT_EN
        // Watchdog in S_ACK with an engine that never responds
        model_en = 1'b0;
        cmd_valid = 1'b1; cmd_layers = 8'd1; c = cyc;
        tick();
        cmd_valid = 1'b0;
        chk("to_start", eng_start, 1'b1);
        wait_done(40, "to_done_seen");
        chk("to_done_cyc", cyc, c + 18);
        chk("to_err", seq_err, 2'b10);
        tick();
        model_en = 1'b1;
        cmd_valid = 1'b1; cmd_layers = 8'd0;
        tick();
        cmd_valid = 1'b0;
        chk("to_err_cleared", seq_err, 2'b00);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
